// File: rtl/hs_pkg.sv
// Shared definitions for the command initiator: command encodings, FSM states
// and the entry data rule.
package hs_pkg;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    DRAIN,
    FIN
  } state_t;

  // Entry i carries seed + i; callers truncate to their data width.
  function automatic logic [31:0] entry_val(input logic [31:0] seed, input logic [31:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/hs_outst_cnt.sv
// Up/down counter of reads issued but not yet answered. Next-cycle count and
// full flag are exported so the issuer can decide in the same cycle.
module hs_outst_cnt #(
  parameter int MAX_OUTST = 2,
  parameter int CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt_nxt,
  output logic          full_nxt
);

  logic [CW-1:0] cnt;

  always_comb begin
    // NOTE: default assignment first, so every path drives cnt_nxt and no latch is inferred.
    cnt_nxt = cnt;
    if (inc && !dec)
      cnt_nxt = cnt + CW'(1);
    else if (dec && !inc)
      cnt_nxt = cnt - CW'(1);
  end

  assign full_nxt = (cnt_nxt == CW'(MAX_OUTST));

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/hs_cmd_initiator.sv
// Self-test traffic source: writes a programmed burst to the responder, reads
// it back with bounded outstanding reads and counts data mismatches.
module hs_cmd_initiator
  import hs_pkg::*;
#(
  parameter int DATA_WD   = 4,
  parameter int ADDR_WD   = 4,
  parameter int MAX_OUTST = 2,
  parameter int ERR_WD    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_WD-1:0] cfg_base,
  input  logic [ADDR_WD:0]   cfg_len,
  input  logic [DATA_WD-1:0] cfg_seed,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_cmd,
  output logic [ADDR_WD-1:0] req_addr,
  output logic [DATA_WD-1:0] req_data,
  input  logic               rsp_valid,
  output logic               rsp_ready,
  input  logic [DATA_WD-1:0] rsp_data,
  output logic               busy,
  output logic               done,
  output logic [ERR_WD-1:0]  err_cnt
);

  localparam int              CW       = $clog2(MAX_OUTST + 1);
  localparam logic [ADDR_WD:0] FULL_LEN = {1'b1, {ADDR_WD{1'b0}}};

  state_t             state;
  logic [ADDR_WD:0]   idx, rsp_idx, len_q, cfg_len_c;
  logic [ADDR_WD-1:0] base_q;
  logic [DATA_WD-1:0] seed_q, exp_data;
  logic [CW-1:0]      outst_nxt;
  logic               full_nxt, cmd_fire, rsp_fire, rd_fire, last_cmd;
  logic               load, load_cmd, drop;
  logic [ADDR_WD:0]   load_idx;

  assign cmd_fire  = req_valid & req_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign rd_fire   = cmd_fire & (req_cmd == CMD_RD);
  assign last_cmd  = ((idx + (ADDR_WD+1)'(1)) == len_q);
  assign cfg_len_c = (cfg_len > FULL_LEN) ? FULL_LEN : cfg_len;
  assign exp_data  = DATA_WD'(entry_val(32'(seed_q), 32'(rsp_idx)));

  hs_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CW(CW)) u_outst (
    .clk      (clk),
    .rst      (rst),
    .inc      (rd_fire),
    .dec      (rsp_fire),
    .cnt_nxt  (outst_nxt),
    .full_nxt (full_nxt)
  );

  // Command register loading: a new command is loaded only when nothing is
  // pending or the pending one fires, which keeps the valid rule by construction.
  always_comb begin
    load     = 1'b0;
    drop     = 1'b0;
    load_cmd = CMD_WR;
    load_idx = idx;
    case (state)
      WR: begin
        if (cmd_fire) begin
          load = 1'b1;
          if (last_cmd) begin
            load_cmd = CMD_RD;
            load_idx = '0;
          end else begin
            load_idx = idx + (ADDR_WD+1)'(1);
          end
        end else if (!req_valid) begin
          load = 1'b1;
        end
      end
      RD: begin
        load_cmd = CMD_RD;
        if (cmd_fire) begin
          load_idx = idx + (ADDR_WD+1)'(1);
          if (!last_cmd && !full_nxt)
            load = 1'b1;
          else
            drop = 1'b1;
        end else if (!req_valid && !full_nxt) begin
          load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_cmd   <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
    end else if (load) begin
      req_valid <= 1'b1;
      req_cmd   <= load_cmd;
      req_addr  <= base_q + load_idx[ADDR_WD-1:0];
      req_data  <= (load_cmd == CMD_WR) ? DATA_WD'(entry_val(32'(seed_q), 32'(load_idx))) : '0;
    end else if (drop) begin
      req_valid <= 1'b0;
      req_cmd   <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      rsp_idx   <= '0;
      len_q     <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rsp_ready <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // done trails FIN by one cycle; a start during the done cycle is held off.
      done <= (state == FIN);
      case (state)
        IDLE: begin
          if (start && !done) begin
            base_q  <= cfg_base;
            seed_q  <= cfg_seed;
            len_q   <= cfg_len_c;
            idx     <= '0;
            rsp_idx <= '0;
            if (cfg_len == '0) begin
              state <= FIN;
            end else begin
              state   <= WR;
              busy    <= 1'b1;
              err_cnt <= '0;
            end
          end
        end
        WR: begin
          if (cmd_fire && last_cmd) begin
            state     <= RD;
            rsp_ready <= 1'b1;
          end
        end
        RD: begin
          if (cmd_fire && last_cmd)
            state <= DRAIN;
        end
        DRAIN: begin
          if (outst_nxt == '0) begin
            state     <= FIN;
            rsp_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (cmd_fire)
        idx <= load_idx;
      if (rsp_fire) begin
        rsp_idx <= rsp_idx + (ADDR_WD+1)'(1);
        if (rsp_data != exp_data && err_cnt != '1)
          err_cnt <= err_cnt + ERR_WD'(1);
      end
    end
  end

endmodule

// File: tb/tb_hs_cmd_initiator.sv
// Directed bench for hs_cmd_initiator with a behavioural responder (memory,
// configurable read latency, backpressure and response corruption).
module tb_hs_cmd_initiator;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW:0]   cfg_len = '0;
  logic [DW-1:0] cfg_seed = '0;
  logic          req_valid, req_cmd, rsp_ready, busy, done;
  logic          req_ready = 1'b1;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic [EW-1:0] err_cnt;

  always #5 clk = ~clk;

  hs_cmd_initiator #(.DATA_WD(DW), .ADDR_WD(AW), .MAX_OUTST(2), .ERR_WD(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_seed(cfg_seed), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  int errors = 0;
  int checks = 0;

  // responder configuration
  int lat = 1;
  bit bp_en = 1'b0;
  bit corrupt_en = 1'b0;

  // responder / monitor state
  typedef struct { logic [DW-1:0] data; int due; } rsp_t;
  logic [DW-1:0] mem [16];
  rsp_t          rq[$];
  logic [AW-1:0] wr_addr[$], rd_addr[$];
  logic [DW-1:0] wr_data[$];
  int cyc = 0, outst_m = 0, max_outst = 0, rd_before = 0, rsp_num = 0;
  int stab_viol = 0, vcnt = 0, rd_data_nz = 0;
  bit seen_rsp = 1'b0;
  bit prev_pend = 1'b0;
  logic [AW+DW:0] prev_pay;

  initial begin : responder
    bit cf, rf;
    forever begin
      @(posedge clk);
      cyc++;
      cf = req_valid && req_ready;
      rf = rsp_valid && rsp_ready;
      if (rst) begin
        rq.delete();
        outst_m   = 0;
        prev_pend = 1'b0;
      end else begin
        if (prev_pend && {req_cmd, req_addr, req_data} !== prev_pay) stab_viol++;
        prev_pend = req_valid && !cf;
        prev_pay  = {req_cmd, req_addr, req_data};
        if (req_valid) vcnt++;
        if (rf) begin
          if (rq.size() > 0) void'(rq.pop_front());
          outst_m--;
          seen_rsp = 1'b1;
          rsp_num++;
        end
        if (cf) begin
          if (req_cmd) begin
            mem[req_addr] = req_data;
            wr_addr.push_back(req_addr);
            wr_data.push_back(req_data);
          end else begin
            if (req_data !== '0) rd_data_nz++;
            rd_addr.push_back(req_addr);
            rq.push_back('{mem[req_addr], cyc + lat - 1});
            outst_m++;
            if (!seen_rsp) rd_before++;
          end
        end
        if (outst_m > max_outst) max_outst = outst_m;
      end
      #1;
      req_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst) begin
        rsp_valid = 1'b0;
      end else if (!rsp_valid || rf) begin
        if (rq.size() > 0 && rq[0].due <= cyc && (!bp_en || $urandom_range(0, 1) == 1)) begin
          rsp_valid = 1'b1;
          rsp_data  = rq[0].data ^ ((corrupt_en && (rsp_num == 2 || rsp_num == 5)) ? 4'h1 : 4'h0);
        end else begin
          rsp_valid = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
    vcnt = 0; rd_before = 0; seen_rsp = 1'b0; max_outst = 0;
    rsp_num = 0; stab_viol = 0; rd_data_nz = 0;
  endtask

  // Start one sequence and wait (bounded) for done; cycles counted from the start-sampling edge.
  task automatic run_seq(input string name, input logic [AW-1:0] b, input logic [AW:0] l,
                         input logic [DW-1:0] s, input int budget, input int inj,
                         output int cyc_o, output bit gd, output logic [EW-1:0] eas);
    clear_logs();
    @(posedge clk); #1;
    cfg_base = b; cfg_len = l; cfg_seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; eas = err_cnt; cyc_o = 1; gd = 1'b0;
    while (!gd && cyc_o < budget) begin
      @(posedge clk); #1;
      cyc_o++;
      start = (cyc_o == inj);
      if (start) begin cfg_base = 4'd5; cfg_len = 5'd3; cfg_seed = 4'd0; end
      if (done) gd = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!gd) begin errors++; $display("FAIL %s_done: no done pulse within %0d cycles", name, budget); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_valid, req_cmd, req_addr, req_data, rsp_ready, busy, done, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {req_valid, req_cmd, req_addr, req_data, rsp_ready, busy, done, err_cnt});
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: valid/busy/done=%b, expected 000", {req_valid, busy, done});
    end
  endtask

  task automatic test_ideal();
    int c; bit gd; logic [EW-1:0] eas;
    lat = 1; bp_en = 1'b0;
    run_seq("ideal", 4'd0, 5'd16, 4'd3, 100, -1, c, gd, eas);
    checks++;
    if (c > 36) begin errors++; $display("FAIL ideal_latency: %0d cycles, expected <= 36", c); end
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL ideal_err: got %0d, expected 0", err_cnt); end
    checks++;
    if (wr_addr.size() != 16 || rd_addr.size() != 16) begin
      errors++; $display("FAIL ideal_count: wr=%0d rd=%0d, expected 16/16", wr_addr.size(), rd_addr.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== 4'(3 + i) || rd_addr[i] !== 4'(i)) begin
        errors++;
        $display("FAIL ideal_entry[%0d]: wa=%h wd=%h ra=%h, expected %h/%h/%h",
                 i, wr_addr[i], wr_data[i], rd_addr[i], 4'(i), 4'(3 + i), 4'(i));
      end
    end
    checks++;
    if (rd_data_nz != 0) begin errors++; $display("FAIL ideal_rd_data: %0d reads with nonzero data, expected 0", rd_data_nz); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ideal_done_pulse: done=%b busy=%b, expected 0/0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int c; bit gd; logic [EW-1:0] eas;
    bp_en = 1'b1;
    run_seq("bp", 4'd12, 5'd8, 4'd9, 800, -1, c, gd, eas);
    bp_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_addr[i] !== 4'(12 + i) || wr_data[i] !== 4'(9 + i) || rd_addr[i] !== 4'(12 + i)) begin
        errors++;
        $display("FAIL bp_entry[%0d]: wa=%h wd=%h ra=%h, expected %h/%h/%h",
                 i, wr_addr[i], wr_data[i], rd_addr[i], 4'(12 + i), 4'(9 + i), 4'(12 + i));
      end
    end
    checks++;
    if (wr_addr.size() != 8 || rd_addr.size() != 8) begin
      errors++; $display("FAIL bp_count: wr=%0d rd=%0d, expected 8/8", wr_addr.size(), rd_addr.size());
    end
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: %0d payload changes while pending, expected 0", stab_viol); end
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL bp_err: got %0d, expected 0", err_cnt); end
  endtask

  task automatic test_latency();
    int c; bit gd; logic [EW-1:0] eas;
    lat = 10;
    run_seq("lat", 4'd0, 5'd8, 4'd5, 400, -1, c, gd, eas);
    lat = 1;
    checks++;
    if (rd_before != 2) begin errors++; $display("FAIL lat_reads_before_rsp: got %0d, expected 2", rd_before); end
    checks++;
    if (max_outst != 2) begin errors++; $display("FAIL lat_max_outst: got %0d, expected 2", max_outst); end
    checks++;
    if (err_cnt !== 8'd0 || rd_addr.size() != 8) begin
      errors++; $display("FAIL lat_result: err=%0d reads=%0d, expected 0/8", err_cnt, rd_addr.size());
    end
  endtask

  task automatic test_corrupt();
    int c; bit gd; logic [EW-1:0] eas;
    corrupt_en = 1'b1;
    run_seq("corrupt", 4'd4, 5'd8, 4'd1, 200, -1, c, gd, eas);
    corrupt_en = 1'b0;
    checks++;
    if (err_cnt !== 8'd2) begin errors++; $display("FAIL corrupt_err: got %0d, expected 2", err_cnt); end
    run_seq("clear", 4'd4, 5'd4, 4'd2, 200, -1, c, gd, eas);
    checks++;
    if (eas !== 8'd0) begin errors++; $display("FAIL corrupt_clear_at_start: got %0d, expected 0", eas); end
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL corrupt_clear_end: got %0d, expected 0", err_cnt); end
  endtask

  task automatic test_len0_clamp();
    int c; bit gd; logic [EW-1:0] eas;
    run_seq("len0", 4'd3, 5'd0, 4'd7, 20, -1, c, gd, eas);
    checks++;
    if (c != 2) begin errors++; $display("FAIL len0_latency: done after %0d cycles, expected 2", c); end
    checks++;
    if (vcnt != 0) begin errors++; $display("FAIL len0_no_valid: req_valid seen %0d cycles, expected 0", vcnt); end
    run_seq("clamp", 4'd0, 5'd20, 4'd0, 200, -1, c, gd, eas);
    checks++;
    if (wr_addr.size() != 16 || rd_addr.size() != 16 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clamp_count: wr=%0d rd=%0d err=%0d, expected 16/16/0", wr_addr.size(), rd_addr.size(), err_cnt);
    end
  endtask

  task automatic test_start_busy();
    int c; bit gd; logic [EW-1:0] eas;
    run_seq("busy_start", 4'd0, 5'd8, 4'd4, 200, 4, c, gd, eas);
    checks++;
    if (wr_addr.size() != 8 || rd_addr.size() != 8) begin
      errors++; $display("FAIL busy_start_count: wr=%0d rd=%0d, expected 8/8", wr_addr.size(), rd_addr.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== 4'(4 + i)) begin
        errors++;
        $display("FAIL busy_start_entry[%0d]: wa=%h wd=%h, expected %h/%h", i, wr_addr[i], wr_data[i], 4'(i), 4'(4 + i));
      end
    end
  endtask

  task automatic test_done_start();
    int c, n; bit gd; logic [EW-1:0] eas;
    run_seq("done_start", 4'd0, 5'd1, 4'd0, 50, -1, c, gd, eas);
    start = 1'b1; cfg_base = 4'd8; cfg_len = 5'd2; cfg_seed = 4'd1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_start_blocked: busy=%b, expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL done_start_next_idle: busy=%b, expected 1", busy); end
    n = 0;
    while (!done && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!done || wr_addr.size() != 3 || wr_addr[2] !== 4'd9) begin
      errors++; $display("FAIL done_start_run: done=%b writes=%0d, expected 1/3", done, wr_addr.size());
    end
  endtask

  task automatic test_rst_mid();
    int n; bit bad; int c; bit gd; logic [EW-1:0] eas;
    clear_logs();
    @(posedge clk); #1;
    cfg_base = 4'd0; cfg_len = 5'd16; cfg_seed = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (rd_addr.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (rd_addr.size() < 2) begin errors++; $display("FAIL rst_mid_reach_rd: reads=%0d, expected >= 2", rd_addr.size()); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({req_valid, req_cmd, req_addr, req_data, rsp_ready, busy, done, err_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got %h, expected 0",
               {req_valid, req_cmd, req_addr, req_data, rsp_ready, busy, done, err_cnt});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if ({req_valid, rsp_ready, busy, done} !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_mid_idle: activity after reset release without start, expected none"); end
    run_seq("after_rst", 4'd2, 5'd3, 4'd1, 100, -1, c, gd, eas);
    checks++;
    if (err_cnt !== 8'd0 || wr_addr.size() != 3) begin
      errors++; $display("FAIL after_rst_run: err=%0d writes=%0d, expected 0/3", err_cnt, wr_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_backpressure();
    test_latency();
    test_corrupt();
    test_len0_clamp();
    test_start_busy();
    test_done_start();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_cmd_initiator.md
Name: hs_cmd_initiator

Overview:
- Initiator side of the valid/ready command interface served by the team's `handshake` responder.
- On `start`, it issues a programmed burst of write commands, then the matching read commands.
- It collects the in-order read responses and checks each against the expected data.
- Used as an on-chip self-test/traffic source in front of the responder, replacing bench-driven stimulus.

Parameters:
- DATA_WD, 4, data width of write payload and read response.
- ADDR_WD, 4, address width; address space is 2^ADDR_WD entries.
- MAX_OUTST, 2, maximum reads issued but not yet answered (1..7).
- ERR_WD, 8, width of error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a sequence; ignored while busy.
- cfg_base  in  ADDR_WD  first address.
- cfg_len  in  ADDR_WD+1  number of entries, 0..2^ADDR_WD.
- cfg_seed  in  DATA_WD  data for entry 0.
- req_valid  out  1  command valid (to responder valid_in).
- req_ready  in  1  command accepted (from responder ready_in).
- req_cmd  out  1  1 = write, 0 = read.
- req_addr  out  ADDR_WD  command address.
- req_data  out  DATA_WD  write data; 0 on reads.
- rsp_valid  in  1  read response valid (responder valid_out).
- rsp_ready  out  1  response accept (responder ready_out).
- rsp_data  in  DATA_WD  read response data.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- err_cnt  out  ERR_WD  mismatches in the last sequence, saturating.

Behaviour:
- Reset (async, rst=1) sets all outputs to 0 and the FSM to IDLE. Reset mid-sequence aborts immediately; no drain of the responder is attempted.
- Command fire = req_valid & req_ready. Response fire = rsp_valid & rsp_ready.
- Entry i: addr = (cfg_base + i) mod 2^ADDR_WD, data = (cfg_seed + i) mod 2^DATA_WD.
- cfg_* are sampled on accepted start; a later change mid-run has no effect.
- cfg_len > 2^ADDR_WD is clamped to 2^ADDR_WD.
- FSM states and transitions:
  - IDLE: start & cfg_len==0 goes to FIN. start & cfg_len>0 goes to WR, clears err_cnt, sets busy.
  - WR: issue writes for i = 0..len-1. After the last write fire, go to RD with i = 0.
  - RD: issue reads for i = 0..len-1. After the last read fire, go to DRAIN.
  - DRAIN: wait until all responses are received, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- All req_* and rsp_ready are registered outputs.
  - req_valid rises the cycle after entering WR/RD, i.e. 1 cycle after start.
  - Back-to-back fires are allowed: one command per cycle with req_ready held high.
- Valid rule: once req_valid=1, req_valid/cmd/addr/data are held stable until fire. req_valid is never withdrawn.
- Outstanding counter `outst` (0..MAX_OUTST):
  - +1 on read fire, -1 on response fire; unchanged when both occur in the same cycle.
  - In RD, a new read is presented only when outst < MAX_OUTST, or outst == MAX_OUTST with a response firing this cycle.
- rsp_ready=1 only in RD and DRAIN; 0 elsewhere. Responses arriving in other states are not accepted.
- Responses are in order. Response j is compared with cfg_seed + j. On mismatch, err_cnt increments and saturates at 2^ERR_WD-1.
- A start pulse while busy is dropped and has no effect on the run in progress.
- done and a new start in the same cycle: the start is accepted only on the following IDLE cycle.

Decomposition:
- Package hs_pkg holds:
  - CMD_WR=1'b1, CMD_RD=1'b0;
  - state enum IDLE/WR/RD/DRAIN/FIN;
  - a helper for entry data (seed + index).
- One natural sub-module: hs_outst_cnt, the up/down outstanding counter with full flag, parameterised by MAX_OUTST.

Test Plan:
- Ideal responder (always ready, 1-cycle read latency), base=0, len=16, seed=3:
  - 16 writes with data 3..2 (wrapping mod 16), then 16 reads;
  - done pulse, err_cnt=0;
  - total cycles from start to done within 36.
- Random req_ready/rsp_valid backpressure, base=12, len=8, seed=9:
  - addresses 12..15,0..3 (wrap);
  - payload never changes while req_valid=1 and not fired;
  - err_cnt=0.
- Responder with 10-cycle read latency, MAX_OUTST=2:
  - at most 2 read fires before the first response;
  - outst never exceeds 2.
- Responder corrupts responses 2 and 5:
  - err_cnt=2 after done;
  - err_cnt cleared to 0 at the next start.
- cfg_len=0: done pulses 2 cycles after start, and no req_valid. cfg_len=20: clamped to 16 transactions.
- Edge cases:
  - start pulse during WR is ignored;
  - rst asserted mid-RD drives all outputs to 0 asynchronously;
  - after rst release, the FSM sits in IDLE until the next start.
